// File: rtl/piccolo_keysched_pkg.sv
// Shared constants, state and version encodings for the Piccolo key scheduler.
package piccolo_keysched_pkg;

  // Round counts per version
  localparam int unsigned R80  = 25;
  localparam int unsigned R128 = 31;

  // Round-constant masks
  localparam logic [31:0] CON80_MASK  = 32'h0f1e2d3c;
  localparam logic [31:0] CON128_MASK = 32'h6547a98b;

  // Version encodings
  localparam logic VER_80  = 1'b0;
  localparam logic VER_128 = 1'b1;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

  function automatic logic [31:0] con_mask(input logic ver);
    return (ver == VER_80) ? CON80_MASK : CON128_MASK;
  endfunction

endpackage

// File: rtl/piccolo_keysched_con.sv
// Raw Piccolo round constant for round i (unmasked): {c,0,c,00,c,0,c} with c = i+1.
module piccolo_keysched_con (
  input  logic [4:0]  round,
  output logic [31:0] con
);

  logic [4:0] c;

  // Assemble the 32-bit constant pair con_2i|con_2i+1
  always_comb begin
    c   = round + 5'd1;
    con = {c, 5'd0, c, 2'b00, c, 5'd0, c};
  end

endmodule

// File: rtl/piccolo_keysched.sv
// Sequential Piccolo-80/128 key scheduler: one 32-bit round-key pair per advance.
module piccolo_keysched
  import piccolo_keysched_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         version,
  input  logic [127:0] key_in,
  input  logic         start,
  input  logic         adv,
  output logic         busy,
  output logic         rk_valid,
  output logic [31:0]  rk,
  output logic [4:0]   round_idx,
  output logic [63:0]  wk,
  output logic         done
);

  state_e      state_q;
  logic        version_q;
  logic [15:0] kf_q [8];
  logic [4:0]  round_q;
  logic [2:0]  mod5_q;
  logic [2:0]  idx_q;      // (2i+2) mod 8 for the current round
  logic        busy_q;
  logic        rk_valid_q;
  logic        done_q;
  logic [31:0] rk_q;
  logic [63:0] wk_q;

  logic [15:0] key_w   [8];
  logic [15:0] kf_perm [8];
  logic [15:0] kf_next [8];
  logic [4:0]  i_next;
  logic [4:0]  con_round;
  logic [4:0]  last_round;
  logic [2:0]  mod5_next;
  logic [2:0]  idx_next;
  logic [31:0] con_raw;
  logic [31:0] sel;
  logic [31:0] rk_start;
  logic [31:0] rk_next;
  logic [63:0] wk_start;

  // Round 0 during IDLE (for the start load), next round while running
  assign con_round = (state_q == StRun) ? i_next : 5'd0;

  piccolo_keysched_con u_con (
    .round (con_round),
    .con   (con_raw)
  );

  // Split the big-endian key into 16-bit words and derive whitening keys
  always_comb begin
    key_w[0] = key_in[127:112];
    key_w[1] = key_in[111:96];
    key_w[2] = key_in[95:80];
    key_w[3] = key_in[79:64];
    key_w[4] = key_in[63:48];
    key_w[5] = key_in[47:32];
    key_w[6] = key_in[31:16];
    key_w[7] = key_in[15:0];
    wk_start = {key_w[0][15:8], key_w[1][7:0],
                key_w[1][15:8], key_w[0][7:0],
                key_w[4][15:8], (version == VER_128) ? key_w[7][7:0] : key_w[3][7:0],
                (version == VER_128) ? key_w[7][15:8] : key_w[3][15:8], key_w[4][7:0]};
    // Round 0 selects k2|k3 for both versions
    rk_start = con_raw ^ con_mask(version) ^ {key_w[2], key_w[3]};
  end

  // Next-round key: counters, optional 128-bit word permutation, word selection
  always_comb begin
    i_next     = round_q + 5'd1;
    mod5_next  = (mod5_q == 3'd4) ? 3'd0 : mod5_q + 3'd1;
    idx_next   = idx_q + 3'd2;
    last_round = (version_q == VER_128) ? 5'(R128 - 1) : 5'(R80 - 1);

    kf_perm[0] = kf_q[2];
    kf_perm[1] = kf_q[1];
    kf_perm[2] = kf_q[6];
    kf_perm[3] = kf_q[7];
    kf_perm[4] = kf_q[0];
    kf_perm[5] = kf_q[3];
    kf_perm[6] = kf_q[4];
    kf_perm[7] = kf_q[5];

    // idx_next == 0 exactly when the next round has i mod 4 == 3
    kf_next = kf_q;
    if (version_q == VER_128 && idx_next == 3'd0) begin
      kf_next = kf_perm;
    end

    sel = {kf_q[2], kf_q[3]};
    if (version_q == VER_128) begin
      sel = {kf_next[idx_next], kf_next[idx_next + 3'd1]};
    end else begin
      unique case (mod5_next)
        3'd0, 3'd2: sel = {kf_q[2], kf_q[3]};
        3'd1, 3'd4: sel = {kf_q[0], kf_q[1]};
        3'd3:       sel = {kf_q[4], kf_q[4]};
        default:    sel = {kf_q[2], kf_q[3]};
      endcase
    end

    rk_next = con_raw ^ con_mask(version_q) ^ sel;
  end

  // Control FSM with registered outputs and key/counter state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      version_q  <= VER_80;
      round_q    <= 5'd0;
      mod5_q     <= 3'd0;
      idx_q      <= 3'd0;
      busy_q     <= 1'b0;
      rk_valid_q <= 1'b0;
      done_q     <= 1'b0;
      rk_q       <= 32'd0;
      wk_q       <= 64'd0;
      for (int w = 0; w < 8; w++) kf_q[w] <= 16'd0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            for (int w = 0; w < 8; w++) kf_q[w] <= key_w[w];
            version_q  <= version;
            wk_q       <= wk_start;
            rk_q       <= rk_start;
            round_q    <= 5'd0;
            mod5_q     <= 3'd0;
            idx_q      <= 3'd2;
            busy_q     <= 1'b1;
            rk_valid_q <= 1'b1;
            state_q    <= StRun;
          end
        end
        StRun: begin
          if (adv) begin
            if (round_q == last_round) begin
              state_q    <= StIdle;
              busy_q     <= 1'b0;
              rk_valid_q <= 1'b0;
              done_q     <= 1'b1;
              round_q    <= 5'd0;
            end else begin
              round_q <= i_next;
              mod5_q  <= mod5_next;
              idx_q   <= idx_next;
              kf_q    <= kf_next;
              rk_q    <= rk_next;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy      = busy_q;
  assign rk_valid  = rk_valid_q;
  assign rk        = rk_q;
  assign round_idx = round_q;
  assign wk        = wk_q;
  assign done      = done_q;

endmodule

// File: tb/tb_piccolo_keysched.sv
// Self-checking bench for piccolo_keysched: vector table plus corner-case sequences.
module tb_piccolo_keysched;

  logic         clk;
  logic         reset;
  logic         version;
  logic [127:0] key_in;
  logic         start;
  logic         adv;
  logic         busy;
  logic         rk_valid;
  logic [31:0]  rk;
  logic [4:0]   round_idx;
  logic [63:0]  wk;
  logic         done;

  piccolo_keysched dut (
    .clk       (clk),
    .reset     (reset),
    .version   (version),
    .key_in    (key_in),
    .start     (start),
    .adv       (adv),
    .busy      (busy),
    .rk_valid  (rk_valid),
    .rk        (rk),
    .round_idx (round_idx),
    .wk        (wk),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit           ver;
    logic [127:0] key;
    logic [31:0]  rk0;
    logic [63:0]  wk;
  } vec_t;

  vec_t        vecs [8];
  logic [31:0] exp_rk [31];
  logic [63:0] exp_wk;
  int          n_chk;
  int          n_pass;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) $display("FAIL %s: got %h, want %h", name, act, expv);
    else n_pass++;
  endtask

  // Reference: Piccolo schedule over 16-bit subkeys rk_j, j = 0..2R-1
  task automatic model(input bit ver, input logic [127:0] key);
    logic [15:0] k [8];
    logic [15:0] t [8];
    logic [15:0] rk16 [62];
    logic [15:0] w16;
    logic [31:0] c;
    logic [31:0] con;
    int          nr;
    int          r;
    for (int w = 0; w < 8; w++) k[w] = key[127 - 16 * w -: 16];
    exp_wk = {k[0][15:8], k[1][7:0], k[1][15:8], k[0][7:0],
              k[4][15:8], ver ? k[7][7:0] : k[3][7:0],
              ver ? k[7][15:8] : k[3][15:8], k[4][7:0]};
    nr = ver ? 31 : 25;
    for (int j = 0; j < 2 * nr; j++) begin
      r   = j / 2;
      c   = 32'(r + 1);
      con = ((c << 27) | (c << 17) | (c << 10) | c) ^ (ver ? 32'h6547a98b : 32'h0f1e2d3c);
      if (ver) begin
        if ((j + 2) % 8 == 0) begin
          t = k;
          k[0] = t[2]; k[1] = t[1]; k[2] = t[6]; k[3] = t[7];
          k[4] = t[0]; k[5] = t[3]; k[6] = t[4]; k[7] = t[5];
        end
        w16 = k[(j + 2) % 8];
      end else begin
        case (r % 5)
          0, 2:    w16 = (j % 2 == 0) ? k[2] : k[3];
          1, 4:    w16 = (j % 2 == 0) ? k[0] : k[1];
          default: w16 = k[4];
        endcase
      end
      rk16[j] = w16 ^ ((j % 2 == 0) ? con[31:16] : con[15:0]);
    end
    for (int i = 0; i < 31; i++) exp_rk[i] = (i < nr) ? {rk16[2 * i], rk16[2 * i + 1]} : 32'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic do_start(input bit ver, input logic [127:0] key);
    version = ver;
    key_in  = key;
    start   = 1'b1;
    step();
    start   = 1'b0;
    key_in  = {$urandom, $urandom, $urandom, $urandom};
    version = ~ver;
  endtask

  // Advance back-to-back from round first through the last round; check done pulse
  task automatic run_rounds(input int first, input int nr, input string tag);
    for (int r = first; r < nr; r++) begin
      chk({tag, " rk"}, 64'(rk), 64'(exp_rk[r]));
      chk({tag, " round_idx"}, 64'(round_idx), 64'(r));
      adv = 1'b1;
      step();
    end
    adv = 1'b0;
    chk({tag, " done pulse"}, 64'(done), 64'd1);
    chk({tag, " rk_valid after last"}, 64'(rk_valid), 64'd0);
    chk({tag, " busy after last"}, 64'(busy), 64'd0);
    step();
    chk({tag, " done one cycle"}, 64'(done), 64'd0);
  endtask

  task automatic advance_to(input int target);
    for (int r = 0; r < target; r++) begin
      adv = 1'b1;
      step();
    end
    adv = 1'b0;
  endtask

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    reset   = 1'b1;
    version = 1'b0;
    key_in  = '0;
    start   = 1'b0;
    adv     = 1'b0;

    // Known vectors (hand-derived) then random keys with model-derived expectations
    vecs[0].ver = 1'b0;
    vecs[0].key = 128'h00112233445566778899_000000000000;
    vecs[0].rk0 = 32'h43494f4a;
    vecs[0].wk  = 64'h0033_2211_8877_6699;
    vecs[1].ver = 1'b1;
    vecs[1].key = 128'h00112233445566778899aabbccddeeff;
    vecs[1].rk0 = 32'h2910cbfd;
    vecs[1].wk  = 64'h0033_2211_88ff_ee99;
    for (int v = 2; v < 8; v++) begin
      vecs[v].ver = (v >= 5);
      vecs[v].key = {$urandom, $urandom, $urandom, $urandom};
      model(vecs[v].ver, vecs[v].key);
      vecs[v].rk0 = exp_rk[0];
      vecs[v].wk  = exp_wk;
    end

    for (int v = 0; v < 8; v++) begin
      model(vecs[v].ver, vecs[v].key);
      do_reset();
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset rk_valid", 64'(rk_valid), 64'd0);
      chk("reset done", 64'(done), 64'd0);
      chk("reset rk", 64'(rk), 64'd0);
      chk("reset wk", wk, 64'd0);
      chk("reset round_idx", 64'(round_idx), 64'd0);
      do_start(vecs[v].ver, vecs[v].key);
      chk("start rk_valid", 64'(rk_valid), 64'd1);
      chk("start busy", 64'(busy), 64'd1);
      chk("rk0", 64'(rk), 64'(vecs[v].rk0));
      chk("wk", wk, vecs[v].wk);
      run_rounds(0, vecs[v].ver ? 31 : 25, vecs[v].ver ? "p128" : "p80");
      chk("wk held after done", wk, vecs[v].wk);
    end

    // Stall at round 7 with start pulses and key_in churn
    model(1'b0, vecs[2].key);
    do_start(1'b0, vecs[2].key);
    advance_to(7);
    for (int c = 0; c < 10; c++) begin
      start  = c[0];
      key_in = {$urandom, $urandom, $urandom, $urandom};
      step();
      chk("stall rk", 64'(rk), 64'(exp_rk[7]));
      chk("stall round_idx", 64'(round_idx), 64'd7);
      chk("stall rk_valid", 64'(rk_valid), 64'd1);
    end
    start = 1'b0;
    run_rounds(7, 25, "after stall");

    // Reset at round 12: no done pulse, fresh start reproduces round 0
    model(1'b1, vecs[6].key);
    do_start(1'b1, vecs[6].key);
    advance_to(12);
    chk("pre-reset round_idx", 64'(round_idx), 64'd12);
    chk("pre-reset rk", 64'(rk), 64'(exp_rk[12]));
    do_reset();
    chk("mid reset busy", 64'(busy), 64'd0);
    chk("mid reset rk_valid", 64'(rk_valid), 64'd0);
    chk("mid reset done", 64'(done), 64'd0);
    chk("mid reset wk", wk, 64'd0);
    step();
    chk("mid reset no done", 64'(done), 64'd0);
    do_start(1'b1, vecs[6].key);
    chk("restart rk0", 64'(rk), 64'(exp_rk[0]));
    chk("restart wk", wk, exp_wk);

    // Start coinciding with the final advance is ignored
    advance_to(30);
    chk("final round_idx", 64'(round_idx), 64'd30);
    start  = 1'b1;
    adv    = 1'b1;
    key_in = vecs[0].key;
    step();
    start  = 1'b0;
    adv    = 1'b0;
    chk("start+final done", 64'(done), 64'd1);
    chk("start+final rk_valid", 64'(rk_valid), 64'd0);
    step();
    chk("start+final stays idle", 64'(rk_valid), 64'd0);
    chk("start+final busy", 64'(busy), 64'd0);

    // adv in IDLE is ignored
    for (int c = 0; c < 3; c++) begin
      adv = 1'b1;
      step();
      chk("idle adv rk_valid", 64'(rk_valid), 64'd0);
      chk("idle adv done", 64'(done), 64'd0);
    end
    adv = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
